dmg_bus_dma: RTL

- Bus owner between the sm83 CPU and the memory-map decoder.
- Adds an OAM DMA engine: a CPU write to the DMA register copies DMA_LEN bytes from {src_hi, 8'h00} into OAM, one byte per M-cycle.
- While DMA runs, the CPU is restricted to the HRAM window and the DMA register; the engine owns the main bus.
- Sits between the cpu and the casex decode in the top level, and advances on the shared cpu_ce M-cycle strobe.

---
 rtl/dmg_pkg.sv | 30 +++
 rtl/dmg_dma_engine.sv | 92 +++++++++
 rtl/dmg_bus_dma.sv | 96 +++++++++
 3 files changed

// File: rtl/dmg_pkg.sv
// Shared definitions for the DMG bus owner and its OAM DMA engine:
// memory-map region patterns, DMA register / HRAM window addresses,
// the DMA state encoding and the source-page remap helper.
package dmg_pkg;

    // Memory-map region decode as (mask, value) pairs: addr & MASK == VAL
    localparam logic [15:0] MAP_ROM_MASK  = 16'h8000;
    localparam logic [15:0] MAP_ROM_VAL   = 16'h0000;
    localparam logic [15:0] MAP_VRAM_MASK = 16'hE000;
    localparam logic [15:0] MAP_VRAM_VAL  = 16'h8000;
    localparam logic [15:0] MAP_WRAM_MASK = 16'hE000;
    localparam logic [15:0] MAP_WRAM_VAL  = 16'hC000;
    localparam logic [15:0] MAP_PPU_MASK  = 16'hFFF0;
    localparam logic [15:0] MAP_PPU_VAL   = 16'hFF40;
    localparam logic [15:0] MAP_HRAM_MASK = 16'hFF80;
    localparam logic [15:0] MAP_HRAM_VAL  = 16'hFF80;

    localparam int unsigned DMA_LEN_DEF = 160;
    localparam logic [15:0] DMA_REG     = 16'hFF46;
    localparam logic [15:0] HRAM_LO     = 16'hFF80;
    localparam logic [15:0] HRAM_HI     = 16'hFFFE;

    typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} dma_state_t;

    // Pages E0..FF alias the echo region; fold them back onto C0..DF.
    function automatic logic [7:0] dma_src_remap(input logic [7:0] d);
        return (d >= 8'hE0) ? (d - 8'h20) : d;
    endfunction

endpackage

// File: rtl/dmg_dma_engine.sv
// OAM DMA engine: source page register, byte index counter, and the
// one-deep read->OAM write pipeline. Everything advances only on ce.
// A trigger always wins: it restarts from START with idx=0, and any
// byte already pending is still presented to OAM for one more M-cycle.
module dmg_dma_engine
    import dmg_pkg::*;
#(
    parameter int unsigned DMA_LEN = 160,
    parameter int unsigned OAM_AW  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                trig_i,
    input  logic [7:0]          trig_data_i,
    input  logic [7:0]          bus_d_rd_i,
    output dma_state_t          state_o,
    output logic [7:0]          src_hi_o,
    output logic [15:0]         rd_addr_o,
    output logic [OAM_AW-1:0]   oam_addr_o,
    output logic                oam_write_o,
    output logic [7:0]          oam_d_wr_o
);

    localparam int unsigned      IDX_W = $clog2(DMA_LEN);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(DMA_LEN - 1);

    dma_state_t       state_q, state_d;
    logic [7:0]       src_hi_q, src_hi_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             wr_pend_q, wr_pend_d;

    // State registers; reset aborts a transfer and drops the OAM strobe at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            src_hi_q  <= 8'h00;
            idx_q     <= '0;
            wr_idx_q  <= '0;
            rd_data_q <= 8'h00;
            wr_pend_q <= 1'b0;
        end else if (ce) begin
            state_q   <= state_d;
            src_hi_q  <= src_hi_d;
            idx_q     <= idx_d;
            wr_idx_q  <= wr_idx_d;
            rd_data_q <= rd_data_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    // Next state: trigger/restart, then fetch one byte per M-cycle in XFER
    always_comb begin
        state_d   = state_q;
        src_hi_d  = src_hi_q;
        idx_d     = idx_q;
        wr_idx_d  = wr_idx_q;
        rd_data_d = rd_data_q;
        wr_pend_d = 1'b0;
        if (trig_i) begin
            state_d  = START;
            src_hi_d = dma_src_remap(trig_data_i);
            idx_d    = '0;
        end else begin
            case (state_q)
                START: begin
                    state_d = XFER;
                    idx_d   = '0;
                end
                XFER: begin
                    rd_data_d = bus_d_rd_i;
                    wr_idx_d  = idx_q;
                    wr_pend_d = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == LAST) state_d = DRAIN;
                end
                DRAIN:   state_d = IDLE;
                default: ;
            endcase
        end
    end

    assign state_o     = state_q;
    assign src_hi_o    = src_hi_q;
    assign rd_addr_o   = {src_hi_q, 8'(idx_q)};
    assign oam_addr_o  = OAM_AW'(wr_idx_q);
    assign oam_write_o = wr_pend_q;
    assign oam_d_wr_o  = rd_data_q;

endmodule

// File: rtl/dmg_bus_dma.sv
// Bus owner between the CPU and the memory-map decoder. Routes CPU
// accesses to the main bus or the dedicated HRAM port, hosts the DMA
// source register, and hands the main bus to the OAM DMA engine while
// a transfer runs. Optional macro DMG_DMA_BUS_CONFLICT_EN: non-HRAM CPU
// reads during XFER see the byte being fetched instead of 8'hFF.
module dmg_bus_dma #(
    parameter int unsigned DMA_LEN = dmg_pkg::DMA_LEN_DEF,
    parameter logic [15:0] DMA_REG = dmg_pkg::DMA_REG,
    parameter logic [15:0] HRAM_LO = dmg_pkg::HRAM_LO,
    parameter logic [15:0] HRAM_HI = dmg_pkg::HRAM_HI,
    parameter int unsigned OAM_AW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_write,
    input  logic [7:0]        cpu_d_out,
    output logic [7:0]        cpu_d_in,
    output logic [15:0]       bus_addr,
    output logic              bus_write,
    output logic [7:0]        bus_d_wr,
    input  logic [7:0]        bus_d_rd,
    output logic [6:0]        hram_addr,
    output logic              hram_write,
    input  logic [7:0]        hram_d_rd,
    output logic [OAM_AW-1:0] oam_addr,
    output logic              oam_write,
    output logic [7:0]        oam_d_wr,
    output logic              dma_active
);

    dmg_pkg::dma_state_t dma_state;
    logic [7:0]          src_hi;
    logic [15:0]         dma_rd_addr;
    logic                hram_hit;
    logic                reg_hit;
    logic                dma_act;
    logic [7:0]          open_bus;

    assign hram_hit   = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
    assign reg_hit    = (cpu_addr == DMA_REG);
    assign dma_act    = (dma_state != dmg_pkg::IDLE);
    assign dma_active = dma_act;

`ifdef DMG_DMA_BUS_CONFLICT_EN
    assign open_bus = (dma_state == dmg_pkg::XFER) ? bus_d_rd : 8'hFF;
`else
    assign open_bus = 8'hFF;
`endif

    dmg_dma_engine #(
        .DMA_LEN (DMA_LEN),
        .OAM_AW  (OAM_AW)
    ) u_eng (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .trig_i      (cpu_write && reg_hit),
        .trig_data_i (cpu_d_out),
        .bus_d_rd_i  (bus_d_rd),
        .state_o     (dma_state),
        .src_hi_o    (src_hi),
        .rd_addr_o   (dma_rd_addr),
        .oam_addr_o  (oam_addr),
        .oam_write_o (oam_write),
        .oam_d_wr_o  (oam_d_wr)
    );

    // CPU/DMA/HRAM routing; reset forces the bus side quiet
    always_comb begin
        bus_addr   = cpu_addr;
        bus_write  = cpu_write && !hram_hit;
        bus_d_wr   = cpu_d_out;
        hram_addr  = cpu_addr[6:0];
        hram_write = cpu_write && hram_hit;
        cpu_d_in   = bus_d_rd;
        if (dma_act) begin
            bus_addr  = dma_rd_addr;
            bus_write = 1'b0;
            bus_d_wr  = 8'h00;
            cpu_d_in  = open_bus;
        end
        if (hram_hit)     cpu_d_in = hram_d_rd;
        else if (reg_hit) cpu_d_in = src_hi;
        if (rst) begin
            bus_addr   = 16'h0000;
            bus_write  = 1'b0;
            bus_d_wr   = 8'h00;
            hram_addr  = 7'h00;
            hram_write = 1'b0;
            cpu_d_in   = bus_d_rd;
        end
    end

endmodule
